led_catcher_ctrl: RTL and testbench

LED_CATCHER_CTRL -- requirements
Module: led_catcher_ctrl

---
 rtl/led_catcher_ctrl.sv | 167 ++++++++++++++++
 tb/tb_led_catcher_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_catcher_ctrl.sv
// -----------------------------------------------------------------------------
// led_catcher_ctrl
// Reaction game controller. A single lit LED walks across the bar. The player
// presses the button to "catch" it. Catching at TARGET_IDX scores a hit.
// Any other index is a miss. Each catch freezes the display for a while.
// Reaching WIN_SCORE ends the game with all LEDs lit.
// -----------------------------------------------------------------------------
module led_catcher_ctrl #(
  parameter int NUM_LEDS      = 16,
  parameter int STEP_CYCLES   = 10_000_000,
  parameter int FREEZE_CYCLES = 300_000_000,
  parameter int TARGET_IDX    = 7,
  parameter int WIN_SCORE     = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn,
  output logic [NUM_LEDS-1:0] led,
  output logic [3:0]          score,
  output logic                frozen,
  output logic                hit,
  output logic                miss,
  output logic                won
);

  // Counter widths are sized from the terminal count so that the largest
  // value (parameter - 1) is always representable.
  localparam int POS_W  = (NUM_LEDS      > 1) ? $clog2(NUM_LEDS)      : 1;
  localparam int STEP_W = (STEP_CYCLES   > 1) ? $clog2(STEP_CYCLES)   : 1;
  localparam int FRZ_W  = (FREEZE_CYCLES > 1) ? $clog2(FREEZE_CYCLES) : 1;

  localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0]  TARGET_POS = POS_W'(TARGET_IDX);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(STEP_CYCLES - 1);
  localparam logic [FRZ_W-1:0]  FRZ_LAST   = FRZ_W'(FREEZE_CYCLES - 1);
  localparam logic [3:0]        WIN_VAL    = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FREEZE,
    S_WON
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              btn_q;
  logic              rise;
  logic [STEP_W-1:0] step_cnt;
  logic [FRZ_W-1:0]  frz_cnt;
  logic [POS_W-1:0]  pos;
  logic              step_done;
  logic              frz_done;
  logic              on_target;

  // A press acts only on its rising edge, so a held button never re-triggers.
  assign rise      = btn & ~btn_q;
  assign step_done = (step_cnt == STEP_LAST);
  assign frz_done  = (frz_cnt == FRZ_LAST);
  assign on_target = (pos == TARGET_POS);

  // Button history register used for rising-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order of statements or blocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_q <= 1'b0;
    else     btn_q <= btn;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic. A catch takes priority over a same-edge step advance.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (rise) state_nxt = S_RUN;
      S_RUN:    if (rise) state_nxt = S_FREEZE;
      S_FREEZE: if (frz_done) state_nxt = (score == WIN_VAL) ? S_WON : S_RUN;
      S_WON:    if (rise) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Datapath: step/freeze counters, LED position, score and catch pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
      frz_cnt  <= '0;
      pos      <= '0;
      score    <= '0;
      hit      <= 1'b0;
      miss     <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        S_IDLE: begin
          step_cnt <= '0;
          frz_cnt  <= '0;
          pos      <= '0;
          if (rise) score <= '0;
        end
        S_RUN: begin
          if (rise) begin
            // Catch: position is latched as-is and the freeze count starts.
            frz_cnt <= '0;
            if (on_target) begin
              hit <= 1'b1;
              if (score < WIN_VAL) score <= score + 4'd1;
            end else begin
              miss <= 1'b1;
            end
          end else if (step_done) begin
            step_cnt <= '0;
            pos      <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);
          end else begin
            step_cnt <= step_cnt + STEP_W'(1);
          end
        end
        S_FREEZE: begin
          if (frz_done) begin
            frz_cnt  <= '0;
            step_cnt <= '0;
          end else begin
            frz_cnt <= frz_cnt + FRZ_W'(1);
          end
        end
        S_WON: begin
          step_cnt <= '0;
          frz_cnt  <= '0;
          pos      <= '0;
        end
        default: begin
          step_cnt <= '0;
          frz_cnt  <= '0;
          pos      <= '0;
        end
      endcase
    end
  end

  // Output decode from registered state and position only.
  always_comb begin
    led    = '0;
    frozen = 1'b0;
    won    = 1'b0;
    case (state)
      S_RUN:    led[pos] = 1'b1;
      S_FREEZE: begin
        led[pos] = 1'b1;
        frozen   = 1'b1;
      end
      S_WON: begin
        led = '1;
        won = 1'b1;
      end
      default: led = '0;
    endcase
  end

endmodule

// File: tb/tb_led_catcher_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_catcher_ctrl
// Scenario bench for led_catcher_ctrl with short step/freeze times. Each
// scenario pushes the expected per-cycle outputs into a scoreboard queue and
// pops them as the design advances, one sample per clock just after the edge.
// -----------------------------------------------------------------------------
module tb_led_catcher_ctrl;

  localparam int NL = 16;
  localparam int SC = 4;
  localparam int FC = 10;
  localparam int TI = 7;
  localparam int WS = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          btn = 1'b0;
  logic [NL-1:0] led;
  logic [3:0]    score;
  logic          frozen;
  logic          hit;
  logic          miss;
  logic          won;

  led_catcher_ctrl #(
    .NUM_LEDS      (NL),
    .STEP_CYCLES   (SC),
    .FREEZE_CYCLES (FC),
    .TARGET_IDX    (TI),
    .WIN_SCORE     (WS)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .led    (led),
    .score  (score),
    .frozen (frozen),
    .hit    (hit),
    .miss   (miss),
    .won    (won)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] led;
    logic [3:0]  score;
    logic        frozen;
    logic        hit;
    logic        miss;
    logic        won;
  } obs_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic obs_t mk(input logic [15:0] l, input int s,
                              input logic f, input logic h,
                              input logic m, input logic w);
    obs_t o;
    o.led    = l;
    o.score  = 4'(s);
    o.frozen = f;
    o.hit    = h;
    o.miss   = m;
    o.won    = w;
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.led    = led;
    o.score  = score;
    o.frozen = frozen;
    o.hit    = hit;
    o.miss   = miss;
    o.won    = won;
    return o;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("led=%h score=%0d frozen=%b hit=%b miss=%b won=%b",
                     o.led, o.score, o.frozen, o.hit, o.miss, o.won);
  endfunction

  // One-hot pattern for sample i of an uninterrupted walk from position 0.
  function automatic logic [15:0] walk(input int i);
    logic [15:0] one;
    one = 16'h0001;
    return one << ((i / SC) % NL);
  endfunction

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset across two edges, release, and leave one idle sample.
  task automatic do_reset();
    btn = 1'b0;
    rst = 1'b1;
    #1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    obs_t got;
    obs_t exp;
    rst = 1'b0;
    btn = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    got = observe();
    exp = mk(16'h0000, 0, 0, 0, 0, 0);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL reset_async: got %s, expected %s", fmt(got), fmt(exp));
    end
    // Button pressed while in reset, released with the button still high:
    // the first sampled edge after release is a rise.
    btn = 1'b1;
    sb.push_back(mk(16'h0000, 0, 0, 0, 0, 0));
    sb.push_back(walk(0) == 16'h0001 ? mk(16'h0001, 0, 0, 0, 0, 0) : mk(16'hxxxx, 0, 0, 0, 0, 0));
    sb.push_back(mk(16'h0001, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 0) rst = 1'b0;
      got = observe();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL reset_release[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
    end
    btn = 1'b0;
  endtask

  task automatic test_walk();
    obs_t got;
    obs_t exp;
    do_reset();
    for (int i = 0; i < 70; i++) sb.push_back(mk(walk(i), 0, 0, 0, 0, 0));
    btn = 1'b1;
    for (int i = 0; i < 70; i++) begin
      cyc();
      got = observe();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL walk[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
      btn = 1'b0;
    end
  endtask

  task automatic test_hit();
    obs_t got;
    obs_t exp;
    do_reset();
    for (int i = 0; i < 45; i++) begin
      if (i <= 28)      exp = mk(walk(i), 0, 0, 0, 0, 0);
      else if (i == 29) exp = mk(16'h0080, 1, 1, 1, 0, 0);
      else if (i <= 38) exp = mk(16'h0080, 1, 1, 0, 0, 0);
      else if (i <= 42) exp = mk(16'h0080, 1, 0, 0, 0, 0);
      else              exp = mk(16'h0100, 1, 0, 0, 0, 0);
      sb.push_back(exp);
    end
    btn = 1'b1;
    for (int i = 0; i < 45; i++) begin
      cyc();
      got = observe();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL hit[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
      btn = (i == 28);
    end
  endtask

  task automatic test_miss_held();
    obs_t got;
    obs_t exp;
    logic [15:0] one;
    one = 16'h0001;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      if (i <= 8)       exp = mk(walk(i), 0, 0, 0, 0, 0);
      else if (i == 9)  exp = mk(16'h0004, 0, 1, 0, 1, 0);
      else if (i <= 18) exp = mk(16'h0004, 0, 1, 0, 0, 0);
      else if (i <= 31) exp = mk(one << (2 + (i - 19) / SC), 0, 0, 0, 0, 0);
      else if (i == 32) exp = mk(16'h0020, 0, 1, 0, 1, 0);
      else              exp = mk(16'h0020, 0, 1, 0, 0, 0);
      sb.push_back(exp);
    end
    btn = 1'b1;
    for (int i = 0; i < 34; i++) begin
      cyc();
      got = observe();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL miss_held[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
      btn = (i >= 8 && i <= 29) || (i == 31);
    end
  endtask

  task automatic test_collision_win();
    obs_t got;
    obs_t exp;
    do_reset();
    for (int i = 0; i < 70; i++) begin
      if (i <= 28)      exp = mk(walk(i), 0, 0, 0, 0, 0);
      else if (i == 29) exp = mk(16'h0080, 1, 1, 1, 0, 0);
      else if (i <= 38) exp = mk(16'h0080, 1, 1, 0, 0, 0);
      else if (i <= 42) exp = mk(16'h0080, 1, 0, 0, 0, 0);
      else if (i == 43) exp = mk(16'h0080, 2, 1, 1, 0, 0);
      else if (i <= 52) exp = mk(16'h0080, 2, 1, 0, 0, 0);
      else if (i == 53) exp = mk(16'h0080, 2, 0, 0, 0, 0);
      else if (i == 54) exp = mk(16'h0080, 3, 1, 1, 0, 0);
      else if (i <= 63) exp = mk(16'h0080, 3, 1, 0, 0, 0);
      else if (i <= 65) exp = mk(16'hFFFF, 3, 0, 0, 0, 1);
      else if (i <= 67) exp = mk(16'h0000, 3, 0, 0, 0, 0);
      else              exp = mk(16'h0001, 0, 0, 0, 0, 0);
      sb.push_back(exp);
    end
    btn = 1'b1;
    for (int i = 0; i < 70; i++) begin
      cyc();
      got = observe();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL collision_win[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
      btn = (i == 28) || (i == 42) || (i == 53) || (i == 65) || (i == 67);
    end
    btn = 1'b0;
  endtask

  task automatic test_reset_mid_freeze();
    obs_t got;
    obs_t exp;
    do_reset();
    for (int i = 0; i < 34; i++) begin
      if (i <= 28)      exp = mk(walk(i), 0, 0, 0, 0, 0);
      else if (i == 29) exp = mk(16'h0080, 1, 1, 1, 0, 0);
      else              exp = mk(16'h0080, 1, 1, 0, 0, 0);
      sb.push_back(exp);
    end
    btn = 1'b1;
    for (int i = 0; i < 34; i++) begin
      cyc();
      got = observe();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL pre_abort[%0d]: got %s, expected %s", i, fmt(got), fmt(exp));
      end
      btn = (i == 28);
    end
    // Fifth freeze cycle: assert reset between edges.
    #2;
    rst = 1'b1;
    #1;
    got = observe();
    exp = mk(16'h0000, 0, 0, 0, 0, 0);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL abort_async: got %s, expected %s", fmt(got), fmt(exp));
    end
    cyc();
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j < 4) sb.push_back(mk(16'h0000, 0, 0, 0, 0, 0));
      else       sb.push_back(mk(16'h0001, 0, 0, 0, 0, 0));
    end
    for (int j = 0; j < 5; j++) begin
      cyc();
      got = observe();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_bad++;
        $display("FAIL post_abort[%0d]: got %s, expected %s", j, fmt(got), fmt(exp));
      end
      btn = (j == 3);
    end
    btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_walk();
    test_hit();
    test_miss_held();
    test_collision_win();
    test_reset_mid_freeze();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
